muldiv_unit: RTL

- Iterative RV64M multiply/divide execution unit, directly downstream of register_file.
- Consumes read_data1/read_data2 as operands.
- Returns a 64-bit result, destination index and write enable, which feed register_file write_data/rd/reg_write through the writeback mux.
- Uses a shift-add multiplier and a restoring divider, one bit per cycle, with start/busy/done handshake.

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit.
// One multiplier/divider bit per cycle, with a start/busy/done handshake.
// Multiply uses a shift-add accumulator and divide uses a restoring shift/subtract,
// both sharing one 128-bit register.
// Optional macro MULDIV_EARLY_OUT_EN lets divide-by-zero, signed overflow and
// multiply-by-zero skip the iteration phase; results are the same either way.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic                r_sa, r_sb, r_dz;
  logic [XLEN-1:0]     r_a, r_b;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_done, r_rw;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd;

  logic                w_a_sgn, w_b_sgn, w_dz;
  logic [XLEN-1:0]     w_a_mag, w_b_mag;
  logic [XLEN:0]       w_msum;
  logic [2*XLEN:0]     w_dshift;
  logic [XLEN:0]       w_dtrial;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo, w_rem, w_sel;

  // Operand signedness: MULHSU treats rs2 as unsigned, the *U ops treat both as unsigned
  assign w_a_sgn = rs1_data[XLEN-1] &&
                   (op == OP_MUL || op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
  assign w_b_sgn = rs2_data[XLEN-1] &&
                   (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
  assign w_a_mag = w_a_sgn ? -rs1_data : rs1_data;
  assign w_b_mag = w_b_sgn ? -rs2_data : rs2_data;
  assign w_dz    = op[2] && (rs2_data == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic w_ovf, w_mz;
  assign w_ovf = (op == OP_DIV || op == OP_REM) &&
                 (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign w_mz  = !op[2] && ((rs1_data == '0) || (rs2_data == '0));
`endif

  // Multiply step: multiplier sits in the low half and shifts out as the product
  // shifts in, which is the same as adding A<<i for every set bit B[i]
  assign w_msum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  // Divide step: partial remainder in the high half, dividend/quotient in the low half
  assign w_dshift = {r_acc, 1'b0};
  assign w_dtrial = w_dshift[2*XLEN:XLEN] - {1'b0, r_b};

  // Sign fix-up of magnitude results; a zero divisor forces an all-ones quotient,
  // and the remainder then reduces to the signed dividend on its own
  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo  = r_dz ? '1 : ((r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
  assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  // Output select by latched opcode
  always_comb begin
    w_sel = w_prod[XLEN-1:0];
    case (r_op)
      OP_MUL:                      w_sel = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_sel = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_sel = w_quo;
      default:                     w_sel = w_rem;
    endcase
  end

  // Control FSM and datapath; done/reg_write are registered one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dz     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_rw     <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else begin
      r_done <= 1'b0;
      r_rw   <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_op    <= op;
          r_rd    <= rd_in;
          r_sa    <= w_a_sgn;
          r_sb    <= w_b_sgn;
          r_dz    <= w_dz;
          r_a     <= w_a_mag;
          r_b     <= w_b_mag;
          r_cnt   <= '0;
          r_acc   <= op[2] ? {{XLEN{1'b0}}, w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
          r_state <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
          // Preload the accumulator with the final magnitudes and skip iterating
          if (w_dz) begin
            r_acc   <= {w_a_mag, {XLEN{1'b1}}};
            r_state <= S_FIX;
          end else if (w_ovf) begin
            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
            r_state <= S_FIX;
          end else if (w_mz) begin
            r_acc   <= '0;
            r_state <= S_FIX;
          end
`endif
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!r_op[2])
            r_acc <= {w_msum, r_acc[XLEN-1:1]};
          else if (!w_dtrial[XLEN])
            r_acc <= {w_dtrial[XLEN-1:0], w_dshift[XLEN-1:1], 1'b1};
          else
            r_acc <= w_dshift[2*XLEN-1:0];
          if (r_cnt == CNT_W'(XLEN-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_sel;
          r_state  <= S_DONE;
        end
        default: begin
          r_done  <= 1'b1;
          r_rw    <= (r_rd != 5'd0);
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign reg_write = r_rw;
  assign result    = r_result;
  assign rd_out    = r_rd;

endmodule
